sensor_debounce: RTL and testbench

Upstream input conditioner for the gesture FSM. It takes the raw slide-switch or sensor lines, synchronises each one into the clk_50mhz domain, and debounces each channel independently. It outputs a clean level per channel, one-cycle rise/fall strobes, and an any-change strobe. Its clean output feeds the gesture FSM sensor input in place of the raw switch bus.

---
 rtl/sensor_debounce.sv | 144 ++++++++++++++
 tb/tb_sensor_debounce.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sensor_debounce.sv
// Per-channel synchroniser + counter debouncer with clean level, rise/fall and any-change strobes.
// Optional macro SENSOR_DEBOUNCE_SYNC3_EN adds a third synchroniser stage (one extra cycle of latency).
module sensor_debounce #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic            clk_50mhz,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sensor_clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            sensor_changed
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_cfg
      $error("sensor_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
    end
  endgenerate

  logic [N_CH-1:0] r_s1;
  logic [N_CH-1:0] r_s2;
  logic [N_CH-1:0] w_sync;
  logic [N_CH-1:0] w_accept;
  logic [N_CH-1:0] r_clean;
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;
  logic            r_changed;
  logic [CNT_W-1:0] r_cnt   [N_CH];
  state_t           r_state [N_CH];

`ifdef SENSOR_DEBOUNCE_SYNC3_EN
  logic [N_CH-1:0] r_s3;

  // Three-stage synchroniser for the raw asynchronous lines.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_sync = r_s3;
`else
  // Two-stage synchroniser for the raw asynchronous lines.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  assign w_sync = r_s2;
`endif

  // A channel is accepted when it still disagrees on the edge its counter reaches the last count.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((w_sync[i] != r_clean[i]) && (r_cnt[i] == LP_LAST)) begin
        w_accept[i] = 1'b1;
      end else begin
        w_accept[i] = 1'b0;
      end
    end
  end

  // Per-channel STABLE/PENDING debounce FSM with registered level and strobes.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]   <= '0;
        r_state[i] <= ST_STABLE;
      end
      r_clean   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case (r_state[i])
          ST_STABLE: begin
            if (w_sync[i] == r_clean[i]) begin
              r_cnt[i]   <= '0;
              r_state[i] <= ST_STABLE;
            end else if (w_accept[i]) begin
              // Single-cycle debounce: accept on the first mismatch.
              r_clean[i] <= w_sync[i];
              r_cnt[i]   <= '0;
              r_state[i] <= ST_STABLE;
            end else begin
              r_cnt[i]   <= CNT_W'(1);
              r_state[i] <= ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (w_sync[i] == r_clean[i]) begin
              // Bounce back: drop all accumulated credit.
              r_cnt[i]   <= '0;
              r_state[i] <= ST_STABLE;
            end else if (w_accept[i]) begin
              r_clean[i] <= w_sync[i];
              r_cnt[i]   <= '0;
              r_state[i] <= ST_STABLE;
            end else begin
              r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
              r_state[i] <= ST_PENDING;
            end
          end
          default: begin
            r_cnt[i]   <= '0;
            r_state[i] <= ST_STABLE;
          end
        endcase
      end
      r_rise    <= w_accept & w_sync;
      r_fall    <= w_accept & ~w_sync;
      r_changed <= |w_accept;
    end
  end

  assign sensor_clean   = r_clean;
  assign rise           = r_rise;
  assign fall           = r_fall;
  assign sensor_changed = r_changed;

endmodule

// File: tb/tb_sensor_debounce.sv
// Scoreboard bench for sensor_debounce: stimulus pushes expected strobe events, a monitor pops and checks them.
module tb_sensor_debounce;

  localparam int D = 8;
`ifdef SENSOR_DEBOUNCE_SYNC3_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D + 1;
`endif

  typedef struct {
    int         edge_no;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic [3:0] sensor_clean;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       sensor_changed;

  exp_t       sb[$];
  logic [3:0] exp_vec = 4'b0000;
  logic [3:0] mon_clean = 4'b0000;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  sensor_debounce #(.N_CH(4), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk_50mhz      (clk),
    .rst_n          (rst_n),
    .sw_raw         (sw_raw),
    .sensor_clean   (sensor_clean),
    .rise           (rise),
    .fall           (fall),
    .sensor_changed (sensor_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int edge_no, input logic [3:0] new_clean);
    exp_t e;
    e.edge_no = edge_no;
    e.clean   = new_clean;
    e.rise    = new_clean & ~exp_vec;
    e.fall    = ~new_clean & exp_vec;
    exp_vec   = new_clean;
    sb.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (!rst_n) begin
      chk("reset_outputs", {25'd0, sensor_clean, rise, fall, sensor_changed}, 32'd0);
      mon_clean = 4'b0000;
    end else if (sensor_changed !== 1'b0 || (rise | fall) !== 4'b0000) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe at edge %0d: rise %b fall %b chg %b expected none",
                 cyc, rise, fall, sensor_changed);
      end else begin
        e = sb.pop_front();
        chk("strobe_edge", cyc, e.edge_no);
        chk("clean", {28'd0, sensor_clean}, {28'd0, e.clean});
        chk("rise", {28'd0, rise}, {28'd0, e.rise});
        chk("fall", {28'd0, fall}, {28'd0, e.fall});
        chk("changed", {31'd0, sensor_changed}, 32'd1);
        mon_clean = e.clean;
      end
    end else begin
      chk("clean_hold", {28'd0, sensor_clean}, {28'd0, mon_clean});
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout at edge %0d: %0d pending expected 0", cyc, sb.size());
      sb.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    // Reset held with all inputs high.
    rst_n  = 1'b0;
    sw_raw = 4'b1111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_exp(cyc + 1 + LAT, 4'b1111);
    drain(40);

    // All low: simultaneous fall on every channel.
    sw_raw = 4'b0000;
    push_exp(cyc + 1 + LAT, 4'b0000);
    drain(40);

    // Clean step on channel 0.
    sw_raw = 4'b0001;
    push_exp(cyc + 1 + LAT, 4'b0001);
    drain(40);

    // Channel 1 glitch of D-1 cycles: rejected.
    sw_raw = 4'b0011;
    repeat (D - 1) @(negedge clk);
    sw_raw = 4'b0001;
    drain(40);

    // Channel 1 pulse of exactly D cycles: accepted, then falls back.
    sw_raw = 4'b0011;
    push_exp(cyc + 1 + LAT, 4'b0011);
    repeat (D) @(negedge clk);
    sw_raw = 4'b0001;
    push_exp(cyc + 1 + LAT, 4'b0001);
    drain(60);

    // Channel 2 bounce train, then settles high.
    for (int i = 0; i < 10; i++) begin
      sw_raw[2] = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (3) @(negedge clk);
    end
    sw_raw[2] = 1'b1;
    push_exp(cyc + 1 + LAT, 4'b0101);
    drain(40);

    // Simultaneous fall / rise / fall on channels 0 and 2.
    sw_raw = 4'b0000;
    push_exp(cyc + 1 + LAT, 4'b0000);
    drain(40);
    sw_raw = 4'b0101;
    push_exp(cyc + 1 + LAT, 4'b0101);
    drain(40);
    sw_raw = 4'b0000;
    push_exp(cyc + 1 + LAT, 4'b0000);
    drain(40);

    // Reset mid-count on channel 3: pending change discarded, re-debounced after release.
    sw_raw = 4'b1000;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    exp_vec = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(cyc + 1 + LAT, 4'b1000);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
